// File: rtl/irq_scheduler_pkg.sv
// Shared definitions for the interrupt scheduler: port map, source indices,
// controller states and the fixed-priority cause encoder.
package irq_scheduler_pkg;

    localparam logic [7:0] PORT_CAUSE_DEF = 8'h10;
    localparam logic [7:0] PORT_DATA_DEF  = 8'h11;
    localparam logic [7:0] PORT_MASK_DEF  = 8'h12;
    localparam logic [7:0] PORT_EOI_DEF   = 8'h13;

    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned SRC_TEC    = 0;
    localparam int unsigned SRC_CRONO  = 1;
    localparam int unsigned SRC_ALARMA = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Alarm beats chronometer beats keyboard.
    function automatic logic [NUM_SRC-1:0] pick_cause(input logic [NUM_SRC-1:0] elig);
        logic [NUM_SRC-1:0] one_hot;
        one_hot = '0;
        if (elig[SRC_ALARMA])     one_hot[SRC_ALARMA] = 1'b1;
        else if (elig[SRC_CRONO]) one_hot[SRC_CRONO]  = 1'b1;
        else if (elig[SRC_TEC])   one_hot[SRC_TEC]    = 1'b1;
        return one_hot;
    endfunction

endpackage

// File: rtl/irq_scheduler_edge.sv
// Per-source rising-edge detector: registers the source and flags cur & ~prev,
// ignoring any level already present when reset is released.
module irq_edge (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic rise
);

    logic       cur;
    logic       prev;
    logic [1:0] primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= 1'b0;
            prev   <= 1'b0;
            primed <= '0;
        end else begin
            cur    <= src;
            prev   <= cur;
            primed <= {primed[0], 1'b1};
        end
    end

    // Only after two post-reset samples does prev hold a genuine low observation.
    assign rise = cur & ~prev & primed[1];

endmodule

// File: rtl/irq_scheduler.sv
// Three-source interrupt scheduler with pending/mask registers, keyboard byte
// latch with overrun flag, and an IDLE/REQ/SERVICE handshake to the processor.
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter logic [7:0] PORT_CAUSE = PORT_CAUSE_DEF,
    parameter logic [7:0] PORT_DATA  = PORT_DATA_DEF,
    parameter logic [7:0] PORT_MASK  = PORT_MASK_DEF,
    parameter logic [7:0] PORT_EOI   = PORT_EOI_DEF
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       irq_teclado,
    input  logic       irq_crono,
    input  logic       irq_alarma,
    input  logic [7:0] dato_tec,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [7:0] in_port
);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] cause;
    logic [NUM_SRC-1:0] cause_n;
    logic [NUM_SRC-1:0] eoi_clr;
    logic [7:0]         dato_q;
    logic [7:0]         data_reg;
    logic               overrun;
    logic               interrupt_n;
    logic               wr_eoi;
    logic               wr_mask;
    logic               rd_data;
    logic               unused_out_hi;
    state_t             state;
    state_t             state_n;

    assign src = {irq_alarma, irq_crono, irq_teclado};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
        irq_edge u_edge (
            .clk  (reloj),
            .rst  (reset),
            .src  (src[g]),
            .rise (edge_det[g])
        );
    end

    assign wr_eoi        = write_strobe && (port_id == PORT_EOI);
    assign wr_mask       = write_strobe && (port_id == PORT_MASK);
    assign rd_data       = read_strobe && (port_id == PORT_DATA);
    assign eoi_clr       = wr_eoi ? out_port[NUM_SRC-1:0] : '0;
    assign unused_out_hi = ^out_port[7:NUM_SRC];

    // The byte is delayed one cycle so it lines up with the registered edge.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            mask     <= '1;
            dato_q   <= '0;
            data_reg <= '0;
            overrun  <= 1'b0;
        end else begin
            pending <= (pending & ~eoi_clr) | edge_det;
            dato_q  <= dato_tec;
            if (wr_mask)
                mask <= out_port[NUM_SRC-1:0];
            if (edge_det[SRC_TEC])
                data_reg <= dato_q;
            if (edge_det[SRC_TEC] && pending[SRC_TEC])
                overrun <= 1'b1;
            else if (rd_data)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cause     <= '0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_n;
            cause     <= cause_n;
            interrupt <= interrupt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cause_n     = cause;
        interrupt_n = interrupt;
        case (state)
            ST_IDLE: begin
                if ((pending & mask) != '0) begin
                    state_n     = ST_REQ;
                    cause_n     = pick_cause(pending & mask);
                    interrupt_n = 1'b1;
                end
            end
            ST_REQ: begin
                if (interrupt_ack) begin
                    state_n     = ST_SERVICE;
                    interrupt_n = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n     = ST_IDLE;
                interrupt_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        in_port = '0;
        if (port_id == PORT_CAUSE)
            in_port = {overrun, 4'b0000, cause};
        else if (port_id == PORT_DATA)
            in_port = data_reg;
        else if (port_id == PORT_MASK)
            in_port = {5'b00000, mask};
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed scenarios plus a randomized run against an event-level model of the
// interrupt scheduler.
module tb_irq_scheduler;

    localparam logic [7:0] P_CAUSE = 8'h10;
    localparam logic [7:0] P_DATA  = 8'h11;
    localparam logic [7:0] P_MASK  = 8'h12;
    localparam logic [7:0] P_EOI   = 8'h13;

    logic       reloj = 1'b0;
    logic       reset;
    logic       irq_teclado, irq_crono, irq_alarma;
    logic [7:0] dato_tec, port_id, out_port;
    logic       write_strobe, read_strobe, interrupt_ack;
    logic       interrupt;
    logic [7:0] in_port;

    int passed = 0;
    int total  = 0;

    irq_scheduler #(
        .PORT_CAUSE (P_CAUSE),
        .PORT_DATA  (P_DATA),
        .PORT_MASK  (P_MASK),
        .PORT_EOI   (P_EOI)
    ) dut (
        .reloj         (reloj),
        .reset         (reset),
        .irq_teclado   (irq_teclado),
        .irq_crono     (irq_crono),
        .irq_alarma    (irq_alarma),
        .dato_tec      (dato_tec),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
        .in_port       (in_port)
    );

    always #5 reloj = ~reloj;

    // Model: sample k after release is an event iff k >= 2 and samples k-1/k were 0/1;
    // the event lands in pending one cycle later.
    int         m_nsamp;
    logic [2:0] m_last, m_ev, m_cur, m_pend, m_mask, m_cause, m_elig;
    logic [7:0] m_evbyte, m_data;
    logic       m_ovr, m_irq, m_eoi;
    int         m_phase;

    task automatic model_step();
        if (reset) begin
            m_nsamp = 0; m_last = '0; m_ev = '0; m_evbyte = '0; m_pend = '0;
            m_mask = 3'b111; m_cause = '0; m_data = '0; m_ovr = 1'b0; m_irq = 1'b0; m_phase = 0;
        end else begin
            m_eoi  = write_strobe && (port_id == P_EOI);
            m_elig = m_pend & m_mask;
            if (m_phase == 0 && m_elig != 3'b000) begin
                m_phase = 1; m_irq = 1'b1;
                m_cause = m_elig[2] ? 3'b100 : (m_elig[1] ? 3'b010 : 3'b001);
            end else if (m_phase == 1 && interrupt_ack) begin
                m_phase = 2; m_irq = 1'b0;
            end else if (m_phase == 2 && m_eoi) begin
                m_phase = 0;
            end
            if (m_ev[0] && m_pend[0]) m_ovr = 1'b1;
            else if (read_strobe && port_id == P_DATA) m_ovr = 1'b0;
            if (m_ev[0]) m_data = m_evbyte;
            m_pend = (m_pend & ~(m_eoi ? out_port[2:0] : 3'b000)) | m_ev;
            if (write_strobe && port_id == P_MASK) m_mask = out_port[2:0];
            m_cur    = {irq_alarma, irq_crono, irq_teclado};
            m_ev     = (m_nsamp >= 1) ? (m_cur & ~m_last) : 3'b000;
            m_evbyte = dato_tec;
            m_last   = m_cur;
            m_nsamp  = m_nsamp + 1;
        end
    endtask

    initial forever begin
        @(posedge reloj or posedge reset);
        model_step();
    end

    function automatic logic [7:0] m_read(input logic [7:0] p);
        if (p == P_CAUSE) return {m_ovr, 4'b0000, m_cause};
        if (p == P_DATA)  return m_data;
        if (p == P_MASK)  return {5'b00000, m_mask};
        return 8'h00;
    endfunction

    task automatic cyc();
        @(posedge reloj);
        @(negedge reloj);
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
    endtask

    task automatic test_reset();
        total++; if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b want 0", interrupt); else passed++;
        port_id = P_MASK; #1;
        total++; if (in_port !== 8'h07) $display("FAIL reset_mask: got %h want 07", in_port); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h00) $display("FAIL reset_cause: got %h want 00", in_port); else passed++;
        port_id = P_DATA; #1;
        total++; if (in_port !== 8'h00) $display("FAIL reset_data: got %h want 00", in_port); else passed++;
        port_id = 8'h00;
    endtask

    task automatic test_kbd();
        irq_teclado = 1'b1; dato_tec = 8'h1C; cyc();
        irq_teclado = 1'b0; dato_tec = 8'h00; cyc();
        total++; if (interrupt !== 1'b0) $display("FAIL kbd_early: got %b want 0", interrupt); else passed++;
        cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL kbd_latency: got %b want 1", interrupt); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h01) $display("FAIL kbd_cause: got %h want 01", in_port); else passed++;
        port_id = P_DATA; #1;
        total++; if (in_port !== 8'h1C) $display("FAIL kbd_data: got %h want 1c", in_port); else passed++;
        port_id = 8'h00;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        total++; if (interrupt !== 1'b0) $display("FAIL kbd_ack: got %b want 0", interrupt); else passed++;
        wr(P_EOI, 8'h01); cyc(); cyc();
        total++; if (interrupt !== 1'b0) $display("FAIL kbd_after_eoi: got %b want 0", interrupt); else passed++;
    endtask

    task automatic test_two_src();
        irq_crono = 1'b1; irq_alarma = 1'b1; cyc();
        irq_crono = 1'b0; irq_alarma = 1'b0; cyc(); cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL two_irq1: got %b want 1", interrupt); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h04) $display("FAIL two_cause1: got %h want 04", in_port); else passed++;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h04);
        total++; if (interrupt !== 1'b0) $display("FAIL two_gap: got %b want 0", interrupt); else passed++;
        cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL two_irq2: got %b want 1", interrupt); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h02) $display("FAIL two_cause2: got %h want 02", in_port); else passed++;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h02); cyc(); cyc();
        total++; if (interrupt !== 1'b0) $display("FAIL two_done: got %b want 0", interrupt); else passed++;
    endtask

    task automatic test_overrun();
        irq_teclado = 1'b1; dato_tec = 8'h1C; cyc();
        irq_teclado = 1'b0; cyc();
        irq_teclado = 1'b1; dato_tec = 8'h32; cyc();
        irq_teclado = 1'b0; dato_tec = 8'h00; cyc(); cyc();
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h81) $display("FAIL ovr_cause: got %h want 81", in_port); else passed++;
        port_id = P_DATA; #1;
        total++; if (in_port !== 8'h32) $display("FAIL ovr_data: got %h want 32", in_port); else passed++;
        read_strobe = 1'b1; cyc(); read_strobe = 1'b0;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h01) $display("FAIL ovr_cleared: got %h want 01", in_port); else passed++;
        port_id = 8'h00;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h01); cyc(); cyc();
        total++; if (interrupt !== 1'b0) $display("FAIL ovr_done: got %b want 0", interrupt); else passed++;
    endtask

    task automatic test_mask();
        wr(P_MASK, 8'h06);
        irq_teclado = 1'b1; dato_tec = 8'h5A; cyc();
        irq_teclado = 1'b0; cyc(); cyc(); cyc();
        total++; if (interrupt !== 1'b0) $display("FAIL mask_blocked: got %b want 0", interrupt); else passed++;
        total++; if (dut.pending !== 3'b001) $display("FAIL mask_pending: got %b want 001", dut.pending); else passed++;
        port_id = P_MASK; #1;
        total++; if (in_port !== 8'h06) $display("FAIL mask_read: got %h want 06", in_port); else passed++;
        wr(P_MASK, 8'h07);
        total++; if (interrupt !== 1'b0) $display("FAIL mask_unmask0: got %b want 0", interrupt); else passed++;
        cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL mask_unmask1: got %b want 1", interrupt); else passed++;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h01); cyc();
    endtask

    task automatic test_eoi_collide();
        irq_teclado = 1'b1; dato_tec = 8'h77; cyc();
        irq_teclado = 1'b0; cyc(); cyc();
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        irq_teclado = 1'b1; dato_tec = 8'h78; cyc();
        irq_teclado = 1'b0;
        wr(P_EOI, 8'h01);
        total++; if (dut.pending[0] !== 1'b1) $display("FAIL collide_pending: got %b want 1", dut.pending[0]); else passed++;
        total++; if (interrupt !== 1'b0) $display("FAIL collide_gap: got %b want 0", interrupt); else passed++;
        cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL collide_irq: got %b want 1", interrupt); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h81) $display("FAIL collide_cause: got %h want 81", in_port); else passed++;
        port_id = P_DATA; read_strobe = 1'b1; cyc(); read_strobe = 1'b0; port_id = 8'h00;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h01); cyc();
    endtask

    task automatic test_reset_service();
        wr(P_MASK, 8'h03);
        irq_crono = 1'b1; cyc();
        irq_crono = 1'b0; cyc(); cyc();
        reset = 1'b1; #1;
        total++; if (interrupt !== 1'b0) $display("FAIL rst_req_irq: got %b want 0", interrupt); else passed++;
        cyc(); reset = 1'b0; cyc(); cyc();
        irq_crono = 1'b1; cyc();
        irq_crono = 1'b0; cyc(); cyc();
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        irq_alarma = 1'b1;
        reset = 1'b1; #1;
        total++; if (interrupt !== 1'b0) $display("FAIL rst_svc_irq: got %b want 0", interrupt); else passed++;
        port_id = P_MASK; #1;
        total++; if (in_port !== 8'h07) $display("FAIL rst_svc_mask: got %h want 07", in_port); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h00) $display("FAIL rst_svc_cause: got %h want 00", in_port); else passed++;
        port_id = 8'h00;
        cyc(); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++; if (interrupt !== 1'b0) $display("FAIL rst_no_replay: cycle %0d got %b want 0", i, interrupt); else passed++;
        end
        irq_alarma = 1'b0; cyc();
        irq_alarma = 1'b1; cyc();
        irq_alarma = 1'b0; cyc(); cyc();
        total++; if (interrupt !== 1'b1) $display("FAIL rst_fresh_edge: got %b want 1", interrupt); else passed++;
        port_id = P_CAUSE; #1;
        total++; if (in_port !== 8'h04) $display("FAIL rst_fresh_cause: got %h want 04", in_port); else passed++;
        port_id = 8'h00;
        interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
        wr(P_EOI, 8'h04); cyc();
    endtask

    task automatic test_random();
        logic [7:0] exp_rd;
        for (int i = 0; i < 400; i++) begin
            irq_teclado = ($urandom_range(0, 3) == 0);
            irq_crono   = ($urandom_range(0, 4) == 0);
            irq_alarma  = ($urandom_range(0, 5) == 0);
            dato_tec    = 8'($urandom);
            case ($urandom_range(0, 4))
                0: port_id = P_CAUSE;
                1: port_id = P_DATA;
                2: port_id = P_MASK;
                3: port_id = P_EOI;
                default: port_id = 8'($urandom);
            endcase
            write_strobe  = ($urandom_range(0, 5) == 0);
            read_strobe   = 1'($urandom);
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(0, 2) == 0);
            #1;
            exp_rd = m_read(port_id);
            total++; if (interrupt !== m_irq) $display("FAIL rand_irq: step %0d got %b want %b", i, interrupt, m_irq); else passed++;
            total++; if (in_port !== exp_rd) $display("FAIL rand_in_port: step %0d port %h got %h want %h", i, port_id, in_port, exp_rd); else passed++;
            cyc();
        end
        irq_teclado = 1'b0; irq_crono = 1'b0; irq_alarma = 1'b0;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; port_id = 8'h00;
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        irq_teclado = 1'b0; irq_crono = 1'b0; irq_alarma = 1'b0;
        dato_tec = 8'h00; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        @(negedge reloj); @(negedge reloj);
        test_reset();
        reset = 1'b0;
        cyc(); cyc();
        test_kbd();
        test_two_src();
        test_overrun();
        test_mask();
        test_eoi_collide();
        test_reset_service();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
